// File: rtl/wimax_pkg.sv
// wimax_pkg: shared defaults and types for the WiMax PHY transmit-chain blocks.
//   DATA_W_DEF    - I/Q sample width
//   BURST_LEN_DEF - modulated symbols per burst (one 192-bit block at 2 b/sym)
//   N_GUARD_DEF   - zero samples prepended per burst when the guard is built
//   bb_state_t    - burst-buffer read FSM state
package wimax_pkg;

  localparam int DATA_W_DEF    = 16;
  localparam int BURST_LEN_DEF = 96;
  localparam int N_GUARD_DEF   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GUARD = 2'd1,
    ST_DATA  = 2'd2
  } bb_state_t;

endpackage

// File: rtl/iq_bank_mem.sv
// iq_bank_mem: two-bank I/Q register array.
//   One synchronous write port (we, w_bank, w_idx, w_i, w_q) and one
//   asynchronous read port (r_bank, r_idx -> r_i, r_q).
//   Storage is not reset: bank validity is tracked by the owner's full flags.
module iq_bank_mem #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 96,
  parameter int AW     = 7
) (
  input  logic              clk,
  input  logic              we,
  input  logic              w_bank,
  input  logic [AW-1:0]     w_idx,
  input  logic [DATA_W-1:0] w_i,
  input  logic [DATA_W-1:0] w_q,
  input  logic              r_bank,
  input  logic [AW-1:0]     r_idx,
  output logic [DATA_W-1:0] r_i,
  output logic [DATA_W-1:0] r_q
);

  logic [1:0][2*DATA_W-1:0] rd_word;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic [DEPTH-1:0][2*DATA_W-1:0] row;

    always_ff @(posedge clk)
      if (we && (w_bank == 1'(b))) row[w_idx] <= {w_i, w_q};

    assign rd_word[b] = row[r_idx];
  end

  assign {r_i, r_q} = rd_word[r_bank];

endmodule

// File: rtl/iq_burst_buffer.sv
// iq_burst_buffer: ping-pong I/Q burst buffer between QPSK modulator and
// subcarrier mapper. One bank fills while the other plays out as a
// contiguous burst on a valid/ready stream.
//   clk, rst_n            - clock, async active-low reset
//   s_i, s_q, s_valid     - input samples; s_ready = write bank not full
//   m_i, m_q, m_valid     - output samples; m_ready = downstream accept
//   m_sob, m_eob          - first sample of burst / last data sample
//   overflow              - sticky: sample offered while s_ready was low
// Build option: define IQ_GUARD_EN to prepend N_GUARD zero samples to every
// burst (m_sob then marks the first guard sample).
import wimax_pkg::*;

module iq_burst_buffer #(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int N_GUARD   = N_GUARD_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_i,
  input  logic [DATA_W-1:0] s_q,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_i,
  output logic [DATA_W-1:0] m_q,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_sob,
  output logic              m_eob,
  output logic              overflow
);

  localparam int CW = $clog2(BURST_LEN);
  localparam logic [CW-1:0] LAST_IDX = CW'(BURST_LEN - 1);

`ifdef IQ_GUARD_EN
  localparam bit USE_GUARD = 1'b1;
  localparam int GW = $clog2(N_GUARD + 1);
  localparam logic [GW-1:0] G_LAST = GW'(N_GUARD - 1);
`else
  localparam bit USE_GUARD = 1'b0;
`endif

  // Entry state for every burst
  localparam bb_state_t START_ST = (USE_GUARD && N_GUARD > 0) ? ST_GUARD : ST_DATA;

  logic [1:0]        full, full_n;
  logic              w_bank, r_bank, r_bank_n;
  logic [CW-1:0]     w_cnt, r_cnt, r_cnt_n;
  bb_state_t         state, state_n;
  logic              accept, w_last, rd_done, next_ready;
  logic [DATA_W-1:0] rd_i, rd_q;
`ifdef IQ_GUARD_EN
  logic [GW-1:0]     g_cnt, g_cnt_n;
`endif

  // ---------------- write side ----------------
  assign s_ready = ~full[w_bank];
  assign accept  = s_valid & s_ready;
  assign w_last  = accept & (w_cnt == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      w_bank   <= 1'b0;
      w_cnt    <= '0;
      overflow <= 1'b0;
    end else begin
      if (s_valid & ~s_ready) overflow <= 1'b1;
      if (accept) begin
        if (w_last) begin
          w_cnt  <= '0;
          w_bank <= ~w_bank;
        end else begin
          w_cnt  <= w_cnt + 1'b1;
        end
      end
    end

  // Write completion and read release always hit different banks: a bank
  // under read is full, so the writer can never be accepting into it.
  always_comb begin
    full_n = full;
    if (w_last)  full_n[w_bank] = 1'b1;
    if (rd_done) full_n[r_bank] = 1'b0;
  end

  iq_bank_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (BURST_LEN),
    .AW     (CW)
  ) u_mem (
    .clk    (clk),
    .we     (accept),
    .w_bank (w_bank),
    .w_idx  (w_cnt),
    .w_i    (s_i),
    .w_q    (s_q),
    .r_bank (r_bank),
    .r_idx  (r_cnt),
    .r_i    (rd_i),
    .r_q    (rd_q)
  );

  // ---------------- read side ----------------
  // Follow-on burst can start without a bubble if the other bank is already
  // full, or is being completed by the writer on this same edge. The second
  // term keeps sustained 1 sample/cycle streaming gap-free once the writer
  // has absorbed its one-cycle wait for the freed bank.
  assign next_ready = full[~r_bank] | (w_last & (w_bank != r_bank));

  always_comb begin
    state_n  = state;
    r_cnt_n  = r_cnt;
    r_bank_n = r_bank;
    rd_done  = 1'b0;
    m_valid  = 1'b0;
    m_i      = '0;
    m_q      = '0;
    m_sob    = 1'b0;
    m_eob    = 1'b0;
`ifdef IQ_GUARD_EN
    g_cnt_n  = g_cnt;
`endif
    unique case (state)
      ST_IDLE: begin
        if (full[r_bank]) begin
          state_n = START_ST;
          r_cnt_n = '0;
`ifdef IQ_GUARD_EN
          g_cnt_n = '0;
`endif
        end
      end
`ifdef IQ_GUARD_EN
      ST_GUARD: begin
        m_valid = 1'b1;
        m_sob   = (g_cnt == '0);
        if (m_ready) begin
          if (g_cnt == G_LAST) begin
            g_cnt_n = '0;
            state_n = ST_DATA;
          end else begin
            g_cnt_n = g_cnt + 1'b1;
          end
        end
      end
`endif
      ST_DATA: begin
        m_valid = 1'b1;
        m_i     = rd_i;
        m_q     = rd_q;
`ifndef IQ_GUARD_EN
        m_sob   = (r_cnt == '0);
`endif
        m_eob   = (r_cnt == LAST_IDX);
        if (m_ready) begin
          if (r_cnt == LAST_IDX) begin
            rd_done  = 1'b1;
            r_cnt_n  = '0;
            r_bank_n = ~r_bank;
            state_n  = next_ready ? START_ST : ST_IDLE;
          end else begin
            r_cnt_n  = r_cnt + 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= ST_IDLE;
      r_cnt  <= '0;
      r_bank <= 1'b0;
      full   <= '0;
    end else begin
      state  <= state_n;
      r_cnt  <= r_cnt_n;
      r_bank <= r_bank_n;
      full   <= full_n;
    end

`ifdef IQ_GUARD_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) g_cnt <= '0;
    else        g_cnt <= g_cnt_n;
`endif

endmodule

// File: tb/tb_iq_burst_buffer.sv
// tb_iq_burst_buffer: directed scoreboard bench for iq_burst_buffer.
// Expected output words are queued as input samples are accepted and popped
// as the DUT transfers; stall stability is checked every stalled cycle.
module tb_iq_burst_buffer;

  localparam int DW  = 16;
  localparam int LEN = 96;
`ifdef IQ_GUARD_EN
  localparam int GN = 8;
`else
  localparam int GN = 0;
`endif

  typedef struct packed {
    logic          sob;
    logic          eob;
    logic [DW-1:0] i;
    logic [DW-1:0] q;
  } exp_t;

  logic          clk, rst_n;
  logic [DW-1:0] s_i, s_q, m_i, m_q;
  logic          s_valid, s_ready, m_valid, m_ready, m_sob, m_eob, overflow;

  iq_burst_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .s_i(s_i), .s_q(s_q), .s_valid(s_valid), .s_ready(s_ready),
    .m_i(m_i), .m_q(m_q), .m_valid(m_valid), .m_ready(m_ready),
    .m_sob(m_sob), .m_eob(m_eob), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0, errors = 0;
  exp_t exp_q[$];
  exp_t obs_w, snap;
  logic prev_stall = 1'b0;
  logic ready_hold = 1'b1, rnd_mode = 1'b0, tp_mode = 1'b0, seen_valid = 1'b0;
  int   gaps = 0, pop_cnt = 0;

  assign obs_w = {m_sob, m_eob, m_i, m_q};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // m_ready driver: updated after the main sequence's post-edge writes
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      m_ready = rnd_mode ? 1'($urandom_range(0, 1)) : ready_hold;
    end
  end

  // Output monitor / scoreboard
  always @(negedge clk) begin
    if (!rst_n) prev_stall = 1'b0;
    else begin
      if (prev_stall) begin
        chk("stall_valid", 64'(m_valid), 64'd1);
        chk("stall_hold", 64'(obs_w), 64'(snap));
      end
      if (tp_mode) begin
        if (m_valid) seen_valid = 1'b1;
        else if (seen_valid && exp_q.size() != 0) gaps++;
      end
      if (m_valid && m_ready) begin
        chk("q_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          chk("out_word", 64'(obs_w), 64'(exp_q.pop_front()));
          pop_cnt++;
        end
      end
      prev_stall = m_valid && !m_ready;
      snap       = obs_w;
    end
  end

  task automatic send_one(input logic [DW-1:0] val, input int k);
    int t = 0;
    logic [DW-1:0] nq;
    while (!s_ready && t < 1000) begin
      @(posedge clk); #1;
      t++;
    end
    if (!s_ready) chk("s_ready_wait", 64'(s_ready), 64'd1);
    nq = -val;
    if (k == 0)
      for (int g = 0; g < GN; g++) exp_q.push_back('{sob: (g == 0), eob: 1'b0, i: '0, q: '0});
    exp_q.push_back('{sob: (k == 0 && GN == 0), eob: (k == LEN - 1), i: val, q: nq});
    s_valid = 1'b1; s_i = val; s_q = nq;
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic send_burst(input logic [DW-1:0] base);
    for (int k = 0; k < LEN; k++) send_one(base + DW'(k), k);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
    chk("idle_after_drain", 64'(m_valid), 64'd0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int t;
    rst_n = 1'b0; s_valid = 1'b0; s_i = '0; s_q = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_sob_eob", 64'({m_sob, m_eob}), 64'd0);
    chk("rst_data", 64'({m_i, m_q}), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_s_ready", 64'(s_ready), 64'd1);
    @(posedge clk); #1;

    // Single burst, ready always, latency check
    send_burst(16'd0);
    chk("lat_edge_n", 64'(m_valid), 64'd0);
    @(posedge clk); #1;
    chk("lat_edge_n1", 64'(m_valid), 64'd1);
    chk("lat_sob", 64'(m_sob), 64'd1);
    chk("lat_first_i", 64'(m_i), 64'd0);
    drain();

    // Both banks fill with downstream stalled, then overflow
    ready_hold = 1'b0;
    send_burst(16'd100);
    send_burst(16'd200);
    chk("full_s_ready", 64'(s_ready), 64'd0);
    chk("ovf_before", 64'(overflow), 64'd0);
    s_valid = 1'b1; s_i = 16'hdead; s_q = 16'hbeef;
    @(posedge clk); #1;
    s_valid = 1'b0;
    chk("ovf_after", 64'(overflow), 64'd1);
    chk("ovf_s_ready", 64'(s_ready), 64'd0);
    ready_hold = 1'b1;
    drain();
    chk("ovf_sticky", 64'(overflow), 64'd1);
    pulse_reset();
    chk("ovf_cleared", 64'(overflow), 64'd0);

    // Random back-pressure
    rnd_mode = 1'b1;
    send_burst(16'd300);
    send_burst(16'd400);
    drain();
    rnd_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Sustained streaming: 4 bursts, no output gap
    tp_mode = 1'b1; seen_valid = 1'b0; gaps = 0;
    for (int b = 0; b < 4; b++) send_burst(16'd1000 + DW'(b * 128));
    drain();
    tp_mode = 1'b0;
    chk("tp_gaps", 64'(gaps), 64'd0);
    chk("tp_overflow", 64'(overflow), 64'd0);

    // Reset mid-DATA at r_cnt = 40
    pop_cnt = 0;
    send_burst(16'd2000);
    t = 0;
    while (pop_cnt < GN + 40 && t < 1000) begin
      @(posedge clk); #1;
      t++;
    end
    chk("mid_pop_cnt", 64'(pop_cnt), 64'(GN + 40));
    chk("mid_data", 64'(m_i), 64'd2040);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_valid", 64'(m_valid), 64'd0);
    chk("mid_rst_data", 64'({m_sob, m_eob, m_i, m_q}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_burst(16'd3000);
    drain();
    chk("end_overflow", 64'(overflow), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
